// File: rtl/ifft8_seq_if.sv
// Streaming handshake bundle for the 8-point IFFT: frequency bins in, time samples out.
interface ifft8_seq_if;
  logic               in_valid;
  logic               in_ready;
  logic signed [11:0] in_re;
  logic signed [11:0] in_im;
  logic               out_valid;
  logic               out_ready;
  logic signed [11:0] out_re;
  logic signed [11:0] out_im;
  logic               out_last;

  modport master (
    output in_valid, in_re, in_im, out_ready,
    input  in_ready, out_valid, out_re, out_im, out_last
  );

  modport slave (
    input  in_valid, in_re, in_im, out_ready,
    output in_ready, out_valid, out_re, out_im, out_last
  );
endinterface

// File: rtl/ifft8_seq.sv
// Sequential 8-point radix-2 DIT inverse FFT: one butterfly per clock, 1/2 scaling per stage.
module ifft8_seq (
  input logic       clk,
  input logic       rst,
  ifft8_seq_if.slave bus
);
  typedef enum logic [1:0] {LOAD = 2'd0, CALC = 2'd1, OUT = 2'd2} state_t;

  state_t      state_reg, state_next;
  logic [2:0]  cnt_reg, cnt_next;
  logic [3:0]  bf_reg, bf_next;

  logic signed [13:0] re_mem [8];
  logic signed [13:0] im_mem [8];

  logic [1:0]  stage, pair, tw;
  logic [2:0]  addr_a, addr_b, load_addr;

  logic signed [13:0] a_re, a_im, b_re, b_im;
  logic signed [14:0] ar15, ai15, br15, bi15;
  logic signed [14:0] diff, sum, nsum;
  logic        [23:0] p_diff, p_sum, p_nsum;
  logic signed [14:0] t_re, t_im;
  logic signed [14:0] s_re_a, s_im_a, s_re_b, s_im_b;

  assign stage     = bf_reg[3:2];
  assign pair      = bf_reg[1:0];
  assign load_addr = {cnt_reg[0], cnt_reg[1], cnt_reg[2]};

  // Pair index within a stage maps to the lower address a and its partner a+span.
  always_comb begin
    addr_a = {pair, 1'b0};
    addr_b = {pair, 1'b1};
    tw     = 2'b00;
    case (stage)
      2'd0: begin
        addr_a = {pair, 1'b0};
        addr_b = {pair, 1'b1};
        tw     = 2'b00;
      end
      2'd1: begin
        addr_a = {pair[1], 1'b0, pair[0]};
        addr_b = {pair[1], 1'b1, pair[0]};
        tw     = {pair[0], 1'b0};
      end
      default: begin
        addr_a = {1'b0, pair};
        addr_b = {1'b1, pair};
        tw     = pair;
      end
    endcase
  end

  assign a_re = re_mem[addr_a];
  assign a_im = im_mem[addr_a];
  assign b_re = re_mem[addr_b];
  assign b_im = im_mem[addr_b];

  assign ar15 = {a_re[13], a_re};
  assign ai15 = {a_im[13], a_im};
  assign br15 = {b_re[13], b_re};
  assign bi15 = {b_im[13], b_im};

  assign diff = br15 - bi15;
  assign sum  = br15 + bi15;
  assign nsum = -br15 - bi15;

  // Low product bits are sign-independent, so the floor shift is just a bit slice.
  assign p_diff = {{9{diff[14]}}, diff} * 24'd181;
  assign p_sum  = {{9{sum[14]}},  sum}  * 24'd181;
  assign p_nsum = {{9{nsum[14]}}, nsum} * 24'd181;

  always_comb begin
    t_re = br15;
    t_im = bi15;
    case (tw)
      2'd0: begin t_re = br15;          t_im = bi15;          end
      2'd1: begin t_re = p_diff[22:8];  t_im = p_sum[22:8];   end
      2'd2: begin t_re = -bi15;         t_im = br15;          end
      default: begin t_re = p_nsum[22:8]; t_im = p_diff[22:8]; end
    endcase
  end

  assign s_re_a = ar15 + t_re;
  assign s_im_a = ai15 + t_im;
  assign s_re_b = ar15 - t_re;
  assign s_im_b = ai15 - t_im;

  always_ff @(posedge clk) begin
    if (rst) begin
      if (state_reg == LOAD && bus.in_valid) begin
        re_mem[load_addr] <= {{2{bus.in_re[11]}}, bus.in_re};
        im_mem[load_addr] <= {{2{bus.in_im[11]}}, bus.in_im};
      end else if (state_reg == CALC) begin
        re_mem[addr_a] <= s_re_a[14:1];
        im_mem[addr_a] <= s_im_a[14:1];
        re_mem[addr_b] <= s_re_b[14:1];
        im_mem[addr_b] <= s_im_b[14:1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= LOAD;
      cnt_reg   <= 3'd0;
      bf_reg    <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bf_reg    <= bf_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    bf_next       = bf_reg;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_last  = 1'b0;
    case (state_reg)
      LOAD: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          cnt_next = cnt_reg + 3'd1;
          if (cnt_reg == 3'd7) state_next = CALC;
        end
      end
      CALC: begin
        bf_next = bf_reg + 4'd1;
        if (bf_reg == 4'd11) begin
          bf_next    = 4'd0;
          state_next = OUT;
        end
      end
      OUT: begin
        bus.out_valid = 1'b1;
        bus.out_last  = (cnt_reg == 3'd7);
        if (bus.out_ready) begin
          cnt_next = cnt_reg + 3'd1;
          if (cnt_reg == 3'd7) state_next = LOAD;
        end
      end
      default: state_next = LOAD;
    endcase
  end

  function automatic logic signed [11:0] sat12(input logic signed [13:0] v);
    if (v > 14'sd2047)       return 12'sh7ff;
    else if (v < -14'sd2048) return 12'sh800;
    else                     return v[11:0];
  endfunction

  // Outputs are forced to zero outside OUT so stale buffer data never leaks.
  assign bus.out_re = (state_reg == OUT) ? sat12(re_mem[cnt_reg]) : 12'sd0;
  assign bus.out_im = (state_reg == OUT) ? sat12(im_mem[cnt_reg]) : 12'sd0;
endmodule

// File: tb/tb_ifft8_seq.sv
// Scoreboard bench for ifft8_seq: expected samples are queued at load time and popped on each output handshake.
module tb_ifft8_seq;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ifft8_seq_if bus();
  ifft8_seq dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {int re; int im; bit last;} exp_t;
  exp_t exp_q[$];

  int fr_re[8];
  int fr_im[8];
  int n_checks = 0;
  int n_fail   = 0;
  int first_valid;

  function automatic int wrap14(input int v);
    return ((v + 8192) & 16383) - 8192;
  endfunction

  function automatic int sat(input int v);
    if (v > 2047)  return 2047;
    if (v < -2048) return -2048;
    return v;
  endfunction

  // Independent model of the fixed-point inverse transform.
  task automatic push_model();
    int vr[8];
    int vi[8];
    int a, b, m, span, br, bi, tr, ti, na, nb, nai, nbi;
    for (int k = 0; k < 8; k++) begin
      vr[((k & 1) << 2) | (k & 2) | ((k >> 2) & 1)] = fr_re[k];
      vi[((k & 1) << 2) | (k & 2) | ((k >> 2) & 1)] = fr_im[k];
    end
    for (int s = 0; s < 3; s++) begin
      span = 1 << s;
      for (int g = 0; g < 8; g += 2 * span) begin
        for (int i = 0; i < span; i++) begin
          a = g + i;
          b = a + span;
          m = i * (4 >> s);
          br = vr[b];
          bi = vi[b];
          case (m)
            0: begin tr = br; ti = bi; end
            1: begin tr = ((br - bi) * 181) >>> 8; ti = ((br + bi) * 181) >>> 8; end
            2: begin tr = -bi; ti = br; end
            default: begin tr = ((-br - bi) * 181) >>> 8; ti = ((br - bi) * 181) >>> 8; end
          endcase
          na  = wrap14((vr[a] + tr) >>> 1);
          nb  = wrap14((vr[a] - tr) >>> 1);
          nai = wrap14((vi[a] + ti) >>> 1);
          nbi = wrap14((vi[a] - ti) >>> 1);
          vr[a] = na;  vr[b] = nb;
          vi[a] = nai; vi[b] = nbi;
        end
      end
    end
    for (int n = 0; n < 8; n++) exp_q.push_back('{sat(vr[n]), sat(vi[n]), n == 7});
  endtask

  task automatic set_dc();
    for (int k = 0; k < 8; k++) begin fr_re[k] = 0; fr_im[k] = 0; end
    fr_re[0] = 800;
    for (int n = 0; n < 8; n++) exp_q.push_back('{100, 0, n == 7});
  endtask

  task automatic set_tone();
    int tr[4] = '{100, 0, -100, 0};
    int ti[4] = '{0, 100, 0, -100};
    for (int k = 0; k < 8; k++) begin fr_re[k] = 0; fr_im[k] = 0; end
    fr_re[2] = 800;
    for (int n = 0; n < 8; n++) exp_q.push_back('{tr[n % 4], ti[n % 4], n == 7});
  endtask

  task automatic set_random();
    for (int k = 0; k < 8; k++) begin
      fr_re[k] = int'($urandom_range(0, 4095)) - 2048;
      fr_im[k] = int'($urandom_range(0, 4095)) - 2048;
    end
  endtask

  // Caller must be at a falling edge; beat 0 is driven immediately.
  task automatic send_frame(output int acc);
    int n;
    acc = -1;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_re    = 12'(fr_re[k]);
      bus.in_im    = 12'(fr_im[k]);
      n = 0;
      while (bus.in_ready !== 1'b1 && n < 64) begin
        @(negedge clk);
        n++;
      end
      if (n == 64) begin
        n_checks++;
        n_fail++;
        $display("FAIL send_ready beat %0d: in_ready=%b after 64 cycles, required 1", k, bus.in_ready);
        bus.in_valid = 1'b0;
        return;
      end
      acc = cyc;
      @(posedge clk);
    end
  endtask

  // Drains 8 beats, comparing each against the queue head; ends at a falling edge.
  task automatic recv_frame(input bit random_ready, input bit garbage, input string tag);
    int   waited = 0;
    int   got = 0;
    bit   seen = 0;
    exp_t e;
    first_valid = -1;
    while (got < 8 && waited < 400) begin
      @(negedge clk);
      waited++;
      bus.in_valid = garbage;
      if (garbage) begin
        bus.in_re = 12'($urandom_range(0, 4095));
        bus.in_im = 12'($urandom_range(0, 4095));
      end
      bus.out_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      n_checks++;
      if (bus.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL %s in_ready_busy: in_ready=%b, required 0", tag, bus.in_ready);
      end
      if (bus.out_valid === 1'b1) begin
        if (!seen) begin seen = 1; first_valid = cyc; end
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL %s extra_output: got (%0d,%0d), required no output", tag, bus.out_re, bus.out_im);
        end else begin
          e = exp_q[0];
          if (bus.out_re !== 12'(e.re) || bus.out_im !== 12'(e.im) || bus.out_last !== e.last) begin
            n_fail++;
            $display("FAIL %s beat %0d (ready=%b): got (%0d,%0d,last=%b), required (%0d,%0d,last=%b)",
                     tag, got, bus.out_ready, bus.out_re, bus.out_im, bus.out_last, e.re, e.im, e.last);
          end
          if (bus.out_ready) begin
            void'(exp_q.pop_front());
            got++;
            if (got == 8) bus.in_valid = 1'b0;
          end
        end
      end
    end
    bus.in_valid = 1'b0;
    if (got < 8) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s recv_timeout: got %0d beats, required 8", tag, got);
    end
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s return_to_load: in_ready=%b out_valid=%b, required 1 0", tag, bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic check_idle(input string tag);
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 ||
        bus.out_re !== 12'sd0 || bus.out_im !== 12'sd0) begin
      n_fail++;
      $display("FAIL %s: in_ready=%b out_valid=%b out_last=%b out=(%0d,%0d), required 1 0 0 (0,0)",
               tag, bus.in_ready, bus.out_valid, bus.out_last, bus.out_re, bus.out_im);
    end
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.in_re = '0;
    bus.in_im = '0;
    bus.out_ready = 1'b1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset_held");
    rst = 1'b1;
    @(negedge clk);
    check_idle("reset_released");
  endtask

  task automatic test_dc();
    int acc;
    set_dc();
    send_frame(acc);
    recv_frame(1'b0, 1'b0, "dc");
  endtask

  task automatic test_tone_latency();
    int acc;
    set_tone();
    send_frame(acc);
    recv_frame(1'b0, 1'b1, "tone");
    n_checks++;
    if (first_valid !== acc + 13) begin
      n_fail++;
      $display("FAIL latency: first out_valid at cycle %0d, required %0d", first_valid, acc + 13);
    end
  endtask

  task automatic test_backpressure();
    int acc;
    set_tone();
    send_frame(acc);
    recv_frame(1'b1, 1'b0, "backpressure");
  endtask

  task automatic test_reset_mid_load();
    set_random();
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_re = 12'(fr_re[k]);
      bus.in_im = 12'(fr_im[k]);
      @(posedge clk);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    test_dc();
  endtask

  task automatic test_reset_mid_calc();
    int acc;
    set_random();
    send_frame(acc);
    repeat (5) @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check_idle("reset_mid_calc");
    test_dc();
  endtask

  task automatic test_reset_mid_out();
    int acc;
    int n = 0;
    set_random();
    send_frame(acc);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    while (bus.out_valid !== 1'b1 && n < 64) begin @(negedge clk); n++; end
    if (n == 64) begin
      n_checks++;
      n_fail++;
      $display("FAIL mid_out_wait: out_valid=%b after 64 cycles, required 1", bus.out_valid);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check_idle("reset_mid_out");
    test_tone_latency();
  endtask

  task automatic test_random();
    int acc;
    for (int f = 0; f < 6; f++) begin
      set_random();
      push_model();
      send_frame(acc);
      recv_frame(f[0], (f % 3) == 0, "random");
    end
  endtask

  task automatic test_saturation();
    int sr[8] = '{2047, 2047, 0, -2047, -2047, -2047, 0, 2047};
    int si[8] = '{0, -2047, -2047, -2047, 0, 2047, 2047, 2047};
    int acc;
    for (int k = 0; k < 8; k++) begin fr_re[k] = sr[k]; fr_im[k] = si[k]; end
    push_model();
    send_frame(acc);
    recv_frame(1'b0, 1'b0, "saturation");
  endtask

  task automatic test_back_to_back();
    int acc1, acc2;
    set_dc();
    send_frame(acc1);
    recv_frame(1'b0, 1'b0, "b2b_first");
    set_tone();
    send_frame(acc2);
    recv_frame(1'b0, 1'b0, "b2b_second");
    n_checks++;
    if (acc2 - acc1 !== 28) begin
      n_fail++;
      $display("FAIL frame_period: %0d cycles, required 28", acc2 - acc1);
    end
  endtask

  initial begin
    test_reset();
    test_dc();
    test_tone_latency();
    test_backpressure();
    test_reset_mid_load();
    test_reset_mid_calc();
    test_reset_mid_out();
    test_random();
    test_saturation();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before end of test, required completion");
    $fatal(1, "watchdog expired");
  end
endmodule
